// File: rtl/vp_recovery_if.sv
// Handshake bundle between the value predictor, hazard/flush logic, register-file
// write port and fetch redirect path and the vp_recovery_ctrl consumer.
interface vp_recovery_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int PC_WIDTH      = 32,
  parameter int REG_IDX_WIDTH = 5
);
  logic                     vp_issue;
  logic [PC_WIDTH-1:0]      issue_pc;
  logic [REG_IDX_WIDTH-1:0] issue_dst;
  logic                     vp_done;
  logic                     vp_en_recover;
  logic [DATA_WIDTH-1:0]    vp_data;
  logic                     redirect_ready;

  logic                     spec_active;
  logic                     block_issue;
  logic                     flush;
  logic                     wb_valid;
  logic [REG_IDX_WIDTH-1:0] wb_dst;
  logic [DATA_WIDTH-1:0]    wb_data;
  logic                     redirect_valid;
  logic [PC_WIDTH-1:0]      redirect_pc;
  logic                     recovery_done;
  logic [15:0]              stat_correct;
  logic [15:0]              stat_mispredict;
  logic [15:0]              stat_timeout;

  modport master (
    output vp_issue, issue_pc, issue_dst, vp_done, vp_en_recover, vp_data, redirect_ready,
    input  spec_active, block_issue, flush, wb_valid, wb_dst, wb_data,
           redirect_valid, redirect_pc, recovery_done,
           stat_correct, stat_mispredict, stat_timeout
  );

  modport slave (
    input  vp_issue, issue_pc, issue_dst, vp_done, vp_en_recover, vp_data, redirect_ready,
    output spec_active, block_issue, flush, wb_valid, wb_dst, wb_data,
           redirect_valid, redirect_pc, recovery_done,
           stat_correct, stat_mispredict, stat_timeout
  );
endinterface

// File: rtl/vp_recovery_ctrl.sv
// Tracks the single outstanding value-predicted load and sequences flush, writeback,
// fetch redirect and recovery_done. Outcome counters are built only with VP_RECOVERY_STATS_EN.
module vp_recovery_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int PC_WIDTH      = 32,
  parameter int REG_IDX_WIDTH = 5,
  parameter int FLUSH_CYCLES  = 2,
  parameter int TIMEOUT       = 64
) (
  input logic         clk,
  input logic         rst,
  vp_recovery_if.slave bus
);

  localparam int CNT_MAX = (TIMEOUT > FLUSH_CYCLES) ? TIMEOUT : FLUSH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, SPEC, FLUSH, WB, REDIRECT, DONE} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     cause_misp_q;
  logic [PC_WIDTH-1:0]      pc_q;
  logic [REG_IDX_WIDTH-1:0] dst_q;
  logic [DATA_WIDTH-1:0]    data_q;

  logic ev_issue, ev_misp, ev_correct, ev_timeout, wb_fire;

  logic                     spec_active_q, block_issue_q, flush_q, wb_valid_q;
  logic [REG_IDX_WIDTH-1:0] wb_dst_q;
  logic [DATA_WIDTH-1:0]    wb_data_q;
  logic                     redirect_valid_q, recovery_done_q;
  logic [PC_WIDTH-1:0]      redirect_pc_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Mispredict outranks a simultaneous done; both outrank the timeout.
  always_comb begin
    ev_issue   = (state_q == IDLE) && bus.vp_issue;
    ev_misp    = (state_q == SPEC) && bus.vp_en_recover;
    ev_correct = (state_q == SPEC) && !bus.vp_en_recover && bus.vp_done;
    ev_timeout = (state_q == SPEC) && !bus.vp_en_recover && !bus.vp_done &&
                 (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (ev_issue) begin
        state_d = SPEC;
        cnt_d   = '0;
      end
      SPEC: begin
        if (ev_misp || ev_timeout) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else if (ev_correct) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FLUSH: begin
        if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) state_d = WB;
        else                                   cnt_d   = cnt_q + CNT_W'(1);
      end
      WB:       state_d = REDIRECT;
      REDIRECT: if (bus.redirect_ready) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign wb_fire = (state_d == WB) && cause_misp_q && (dst_q != '0);

  // Control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cause_misp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ev_misp)         cause_misp_q <= 1'b1;
      else if (ev_timeout) cause_misp_q <= 1'b0;
    end
  end

  // Latched load context; only read after being written on this transaction
  always_ff @(posedge clk) begin
    if (ev_issue) begin
      pc_q  <= bus.issue_pc;
      dst_q <= bus.issue_dst;
    end
    if (ev_misp) data_q <= bus.vp_data;
  end

  // Registered outputs decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_active_q    <= 1'b0;
      block_issue_q    <= 1'b0;
      flush_q          <= 1'b0;
      wb_valid_q       <= 1'b0;
      wb_dst_q         <= '0;
      wb_data_q        <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      recovery_done_q  <= 1'b0;
    end else begin
      spec_active_q    <= (state_d == SPEC);
      block_issue_q    <= (state_d != IDLE);
      flush_q          <= (state_d == FLUSH);
      wb_valid_q       <= wb_fire;
      wb_dst_q         <= wb_fire ? dst_q : '0;
      wb_data_q        <= wb_fire ? data_q : '0;
      redirect_valid_q <= (state_d == REDIRECT);
      redirect_pc_q    <= (state_d != REDIRECT) ? '0 :
                          cause_misp_q ? pc_q + PC_WIDTH'(4) : pc_q;
      recovery_done_q  <= (state_d == DONE);
    end
  end

  assign bus.spec_active    = spec_active_q;
  assign bus.block_issue    = block_issue_q;
  assign bus.flush          = flush_q;
  assign bus.wb_valid       = wb_valid_q;
  assign bus.wb_dst         = wb_dst_q;
  assign bus.wb_data        = wb_data_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.recovery_done  = recovery_done_q;

`ifdef VP_RECOVERY_STATS_EN
  logic [15:0] stat_correct_q, stat_misp_q, stat_timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_correct_q <= '0;
      stat_misp_q    <= '0;
      stat_timeout_q <= '0;
    end else begin
      if (ev_correct) stat_correct_q <= sat_inc(stat_correct_q);
      if (ev_misp)    stat_misp_q    <= sat_inc(stat_misp_q);
      if (ev_timeout) stat_timeout_q <= sat_inc(stat_timeout_q);
    end
  end

  assign bus.stat_correct    = stat_correct_q;
  assign bus.stat_mispredict = stat_misp_q;
  assign bus.stat_timeout    = stat_timeout_q;
`else
  assign bus.stat_correct    = 16'd0;
  assign bus.stat_mispredict = 16'd0;
  assign bus.stat_timeout    = 16'd0;
`endif

endmodule

// File: tb/tb_vp_recovery_ctrl.sv
// Directed bench for vp_recovery_ctrl: correct, mispredict, backpressure, timeout/wrap,
// simultaneous outcome, stray issue and mid-recovery reset.
module tb_vp_recovery_ctrl;

`ifdef VP_RECOVERY_STATS_EN
  localparam logic [15:0] STATS = 16'd1;
`else
  localparam logic [15:0] STATS = 16'd0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  vp_recovery_if #(.DATA_WIDTH(32), .PC_WIDTH(32), .REG_IDX_WIDTH(5)) bus ();

  vp_recovery_ctrl #(
    .DATA_WIDTH(32), .PC_WIDTH(32), .REG_IDX_WIDTH(5),
    .FLUSH_CYCLES(2), .TIMEOUT(64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".spec"},   64'(bus.spec_active),     64'd0);
    chk({tag, ".block"},  64'(bus.block_issue),     64'd0);
    chk({tag, ".flush"},  64'(bus.flush),           64'd0);
    chk({tag, ".wbv"},    64'(bus.wb_valid),        64'd0);
    chk({tag, ".wbd"},    64'(bus.wb_dst),          64'd0);
    chk({tag, ".wbdat"},  64'(bus.wb_data),         64'd0);
    chk({tag, ".rv"},     64'(bus.redirect_valid),  64'd0);
    chk({tag, ".rpc"},    64'(bus.redirect_pc),     64'd0);
    chk({tag, ".rdone"},  64'(bus.recovery_done),   64'd0);
    chk({tag, ".sc"},     64'(bus.stat_correct),    64'd0);
    chk({tag, ".sm"},     64'(bus.stat_mispredict), 64'd0);
    chk({tag, ".st"},     64'(bus.stat_timeout),    64'd0);
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] dst);
    bus.vp_issue  = 1'b1;
    bus.issue_pc  = pc;
    bus.issue_dst = dst;
    step();
    bus.vp_issue  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.vp_issue = 1'b0; bus.issue_pc = '0; bus.issue_dst = '0;
    bus.vp_done = 1'b0; bus.vp_en_recover = 1'b0; bus.vp_data = '0;
    bus.redirect_ready = 1'b0;
    step(); step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // Correct prediction
    issue(32'h100, 5'd3);
    chk("ok.spec", 64'(bus.spec_active), 64'd1);
    chk("ok.block", 64'(bus.block_issue), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ok.noflush_wait", 64'(bus.flush), 64'd0);
    end
    bus.vp_done = 1'b1;
    step();
    bus.vp_done = 1'b0;
    chk("ok.spec_fall", 64'(bus.spec_active), 64'd0);
    chk("ok.block_fall", 64'(bus.block_issue), 64'd0);
    chk("ok.noflush", 64'(bus.flush), 64'd0);
    chk("ok.sc", 64'(bus.stat_correct), 64'(STATS));
    step();
    chk("ok.nowb", 64'(bus.wb_valid), 64'd0);
    chk("ok.norv", 64'(bus.redirect_valid), 64'd0);
    chk("ok.nordone", 64'(bus.recovery_done), 64'd0);

    // Mispredict with ready held high
    issue(32'h200, 5'd5);
    bus.vp_en_recover = 1'b1; bus.vp_data = 32'hDEADBEEF; bus.redirect_ready = 1'b1;
    step();
    bus.vp_en_recover = 1'b0; bus.vp_data = '0;
    chk("mp.flush1", 64'(bus.flush), 64'd1);
    chk("mp.spec_off", 64'(bus.spec_active), 64'd0);
    chk("mp.block", 64'(bus.block_issue), 64'd1);
    chk("mp.sm", 64'(bus.stat_mispredict), 64'(STATS));
    step();
    chk("mp.flush2", 64'(bus.flush), 64'd1);
    chk("mp.wb_early", 64'(bus.wb_valid), 64'd0);
    step();
    chk("mp.flush_end", 64'(bus.flush), 64'd0);
    chk("mp.wbv", 64'(bus.wb_valid), 64'd1);
    chk("mp.wbdst", 64'(bus.wb_dst), 64'd5);
    chk("mp.wbdat", 64'(bus.wb_data), 64'hDEADBEEF);
    step();
    chk("mp.wb_once", 64'(bus.wb_valid), 64'd0);
    chk("mp.rv", 64'(bus.redirect_valid), 64'd1);
    chk("mp.rpc", 64'(bus.redirect_pc), 64'h204);
    step();
    chk("mp.rv_off", 64'(bus.redirect_valid), 64'd0);
    chk("mp.rdone", 64'(bus.recovery_done), 64'd1);
    step();
    chk("mp.rdone_pulse", 64'(bus.recovery_done), 64'd0);
    chk("mp.idle", 64'(bus.block_issue), 64'd0);
    bus.redirect_ready = 1'b0;

    // Zero destination and redirect backpressure
    issue(32'h300, 5'd0);
    bus.vp_en_recover = 1'b1; bus.vp_data = 32'h11112222;
    step();
    bus.vp_en_recover = 1'b0;
    chk("bp.flush", 64'(bus.flush), 64'd1);
    step();
    step();
    chk("bp.nowb", 64'(bus.wb_valid), 64'd0);
    chk("bp.wb_block", 64'(bus.block_issue), 64'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("bp.rv_hold", 64'(bus.redirect_valid), 64'd1);
      chk("bp.rpc_hold", 64'(bus.redirect_pc), 64'h304);
      chk("bp.no_rdone", 64'(bus.recovery_done), 64'd0);
      step();
    end
    chk("bp.rv_last", 64'(bus.redirect_valid), 64'd1);
    chk("bp.rpc_last", 64'(bus.redirect_pc), 64'h304);
    bus.redirect_ready = 1'b1;
    step();
    chk("bp.rv_off", 64'(bus.redirect_valid), 64'd0);
    chk("bp.rdone", 64'(bus.recovery_done), 64'd1);
    chk("bp.sm", 64'(bus.stat_mispredict), 64'(2 * STATS));
    step();
    chk("bp.idle", 64'(bus.block_issue), 64'd0);

    // Timeout at the top of the address space
    issue(32'hFFFFFFFC, 5'd7);
    for (int i = 0; i < 63; i++) step();
    chk("to.still_spec", 64'(bus.spec_active), 64'd1);
    chk("to.noflush_yet", 64'(bus.flush), 64'd0);
    step();
    chk("to.flush", 64'(bus.flush), 64'd1);
    chk("to.spec_off", 64'(bus.spec_active), 64'd0);
    chk("to.st", 64'(bus.stat_timeout), 64'(STATS));
    chk("to.sm_same", 64'(bus.stat_mispredict), 64'(2 * STATS));
    step();
    step();
    chk("to.nowb", 64'(bus.wb_valid), 64'd0);
    step();
    chk("to.rv", 64'(bus.redirect_valid), 64'd1);
    chk("to.rpc", 64'(bus.redirect_pc), 64'hFFFFFFFC);
    step();
    chk("to.rdone", 64'(bus.recovery_done), 64'd1);
    step();

    // Stray issue during SPEC, then done+recover together; pc+4 wraps to 0
    issue(32'hFFFFFFFC, 5'd1);
    bus.vp_issue = 1'b1; bus.issue_pc = 32'h500; bus.issue_dst = 5'd9;
    step();
    bus.vp_issue = 1'b0;
    chk("si.spec", 64'(bus.spec_active), 64'd1);
    bus.vp_done = 1'b1; bus.vp_en_recover = 1'b1; bus.vp_data = 32'h12345678;
    step();
    bus.vp_done = 1'b0; bus.vp_en_recover = 1'b0;
    chk("si.flush", 64'(bus.flush), 64'd1);
    chk("si.sc_same", 64'(bus.stat_correct), 64'(STATS));
    step();
    step();
    chk("si.wbv", 64'(bus.wb_valid), 64'd1);
    chk("si.wbdst", 64'(bus.wb_dst), 64'd1);
    chk("si.wbdat", 64'(bus.wb_data), 64'h12345678);
    step();
    chk("si.rpc_wrap", 64'(bus.redirect_pc), 64'h0);
    chk("si.rv", 64'(bus.redirect_valid), 64'd1);
    step();
    chk("si.rdone", 64'(bus.recovery_done), 64'd1);
    step();

    // Asynchronous reset during FLUSH, then normal operation
    issue(32'h600, 5'd2);
    bus.vp_en_recover = 1'b1; bus.vp_data = 32'hCAFEF00D;
    step();
    bus.vp_en_recover = 1'b0;
    chk("rs.flush_before", 64'(bus.flush), 64'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("rs.abort");
    step();
    rst = 1'b0;
    step();
    chk("rs.wb_after", 64'(bus.wb_valid), 64'd0);
    chk("rs.rv_after", 64'(bus.redirect_valid), 64'd0);
    issue(32'h700, 5'd4);
    chk("rs.spec", 64'(bus.spec_active), 64'd1);
    bus.vp_en_recover = 1'b1; bus.vp_data = 32'h0000A5A5;
    step();
    bus.vp_en_recover = 1'b0;
    step();
    step();
    chk("rs.wbdst", 64'(bus.wb_dst), 64'd4);
    chk("rs.wbdat", 64'(bus.wb_data), 64'h0000A5A5);
    step();
    chk("rs.rpc", 64'(bus.redirect_pc), 64'h704);
    step();
    chk("rs.rdone", 64'(bus.recovery_done), 64'd1);
    chk("rs.sm", 64'(bus.stat_mispredict), 64'(STATS));
    step();
    chk("rs.idle", 64'(bus.block_issue), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
